// File: rtl/serial_magnitude_comparator.sv
// Serial magnitude comparator.
// Compares two WIDTH-bit operands 2 bits per cycle, starting at the MSB slice.
// It stops at the first slice that differs.
// Results are reported with a start/busy/done handshake and equal/greater/less flags.
// Optional macro SIGNED_COMPARE_EN: the operands are treated as two's complement.
// The MSB of each latched operand is inverted, which maps signed order onto unsigned order.
module serial_magnitude_comparator #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned IDX_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             equal,
  output logic             a_greater,
  output logic             a_less
);

  localparam int unsigned N = WIDTH / 2;
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(N - 1);

  typedef enum logic {StIdle, StCompare} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] a_eff, b_eff;
  logic [IDX_W-1:0] idx_q;
  logic             done_q, equal_q, greater_q, less_q;
  logic [1:0]       slice_a, slice_b;
  logic             slice_gt, slice_lt, last_slice, decided;

`ifdef SIGNED_COMPARE_EN
  // Flipping the sign bit turns two's-complement order into unsigned order
  localparam logic [WIDTH-1:0] SignMask = {1'b1, {(WIDTH-1){1'b0}}};
  assign a_eff = a_q ^ SignMask;
  assign b_eff = b_q ^ SignMask;
`else
  assign a_eff = a_q;
  assign b_eff = b_q;
`endif

  // Select the 2-bit slice addressed by idx and compare it
  always_comb begin
    slice_a = 2'b00;
    slice_b = 2'b00;
    for (int i = 0; i < int'(N); i++) begin
      if (idx_q == IDX_W'(i)) begin
        slice_a = a_eff[2*i +: 2];
        slice_b = b_eff[2*i +: 2];
      end
    end
    slice_gt   = slice_a > slice_b;
    slice_lt   = slice_a < slice_b;
    last_slice = idx_q == '0;
    decided    = slice_gt || slice_lt || last_slice;
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (start) state_d = StCompare;
      StCompare: if (decided) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Operand capture, slice index and result flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q       <= '0;
      b_q       <= '0;
      idx_q     <= '0;
      done_q    <= 1'b0;
      equal_q   <= 1'b0;
      greater_q <= 1'b0;
      less_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            a_q       <= a;
            b_q       <= b;
            idx_q     <= LastIdx;
            equal_q   <= 1'b0;
            greater_q <= 1'b0;
            less_q    <= 1'b0;
          end
        end
        StCompare: begin
          if (slice_gt) begin
            greater_q <= 1'b1;
            done_q    <= 1'b1;
          end else if (slice_lt) begin
            less_q <= 1'b1;
            done_q <= 1'b1;
          end else if (last_slice) begin
            equal_q <= 1'b1;
            done_q  <= 1'b1;
          end else begin
            idx_q <= idx_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs
  always_comb begin
    busy      = state_q == StCompare;
    done      = done_q;
    equal     = equal_q;
    a_greater = greater_q;
    a_less    = less_q;
  end

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Self-checking bench for serial_magnitude_comparator with WIDTH=8.
// The same bench also covers a build with SIGNED_COMPARE_EN defined.
module tb_serial_magnitude_comparator;

  localparam int unsigned W = 8;
  localparam int unsigned N = W / 2;
  localparam logic [2:0] FGT = 3'b100;
  localparam logic [2:0] FLT = 3'b010;
  localparam logic [2:0] FEQ = 3'b001;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, equal, a_greater, a_less;

  int total = 0;
  int bad = 0;
  int accepts = 0;
  int done_cnt = 0;

  serial_magnitude_comparator #(.WIDTH(W), .IDX_W(2)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .equal(equal), .a_greater(a_greater), .a_less(a_less)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   flags;
    int           lat;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] flags_now();
    return {a_greater, a_less, equal};
  endfunction

  // Reference: whole-word compare plus position of the highest differing bit
  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                       output logic [2:0] f, output int lat);
    logic [W-1:0] x;
`ifdef SIGNED_COMPARE_EN
    if ($signed(ma) > $signed(mb)) f = FGT;
    else if ($signed(ma) < $signed(mb)) f = FLT;
    else f = FEQ;
`else
    if (ma > mb) f = FGT;
    else if (ma < mb) f = FLT;
    else f = FEQ;
`endif
    x = ma ^ mb;
    lat = N;
    for (int p = 0; p < int'(W); p++) begin
      if (x[p]) lat = N - p / 2;
    end
  endtask

  task automatic run_compare(input string name, input logic [W-1:0] va, input logic [W-1:0] vb,
                             input logic [2:0] ef, input int elat);
    int cnt;
    @(negedge clk);
    a = va;
    b = vb;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    accepts++;
    chk({name, " busy_after_accept"}, int'(busy), 1);
    chk({name, " flags_cleared"}, int'(flags_now()), 0);
    cnt = 0;
    while (!done && cnt < int'(N) + 3) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    chk({name, " done"}, int'(done), 1);
    chk({name, " latency"}, cnt, elat);
    chk({name, " flags"}, int'(flags_now()), int'(ef));
    chk({name, " busy_at_done"}, int'(busy), 0);
    @(posedge clk);
    #1;
    chk({name, " done_one_cycle"}, int'(done), 0);
    chk({name, " flags_hold"}, int'(flags_now()), int'(ef));
  endtask

  initial begin
    logic [2:0] mf;
    int         ml;
    int         cnt;
    logic [W-1:0] ra, rb;
    int         sh;

`ifdef SIGNED_COMPARE_EN
    vecs[0] = '{a: 8'hC0, b: 8'h40, flags: FLT, lat: 1};
    vecs[4] = '{a: 8'h00, b: 8'hFF, flags: FGT, lat: 1};
    vecs[5] = '{a: 8'h80, b: 8'h7F, flags: FLT, lat: 1};
`else
    vecs[0] = '{a: 8'hC0, b: 8'h40, flags: FGT, lat: 1};
    vecs[4] = '{a: 8'h00, b: 8'hFF, flags: FLT, lat: 1};
    vecs[5] = '{a: 8'h80, b: 8'h7F, flags: FGT, lat: 1};
`endif
    vecs[1] = '{a: 8'h5A, b: 8'h5A, flags: FEQ, lat: 4};
    vecs[2] = '{a: 8'h24, b: 8'h27, flags: FLT, lat: 4};
    vecs[3] = '{a: 8'h01, b: 8'h00, flags: FGT, lat: 4};
    vecs[6] = '{a: 8'h34, b: 8'h38, flags: FLT, lat: 3};
    vecs[7] = '{a: 8'hFF, b: 8'hFE, flags: FGT, lat: 4};
    vecs[8] = '{a: 8'h00, b: 8'h00, flags: FEQ, lat: 4};

    // Reset state
    #12;
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset flags", int'(flags_now()), 0);
    @(negedge clk);
    reset = 1'b0;

    // Directed table
    foreach (vecs[i]) begin
      run_compare($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].flags, vecs[i].lat);
    end

    // Flags keep their value while idle
    repeat (3) @(posedge clk);
    #1;
    chk("idle flags_hold", int'(flags_now()), int'(vecs[8].flags));

    // Reset in the middle of a comparison aborts it with no done pulse
    @(negedge clk);
    a = 8'h12;
    b = 8'h13;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("midreset busy_before", int'(busy), 1);
    reset = 1'b1;
    #1;
    chk("midreset busy", int'(busy), 0);
    chk("midreset done", int'(done), 0);
    chk("midreset flags", int'(flags_now()), 0);
    @(negedge clk);
    reset = 1'b0;
    cnt = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (done || busy) cnt++;
    end
    chk("midreset no_done_after", cnt, 0);
    run_compare("after_reset", 8'hC0, 8'h40, vecs[0].flags, 1);

    // start held high during busy with changing operands, then back-to-back accept
    @(negedge clk);
    a = 8'h24;
    b = 8'h27;
    start = 1'b1;
    @(posedge clk);
    #1;
    accepts++;
    cnt = 0;
    while (!done && cnt < int'(N) + 3) begin
      a = W'($urandom);
      b = W'($urandom);
      @(posedge clk);
      #1;
      cnt++;
    end
    chk("held_start first_latency", cnt, 4);
    chk("held_start first_flags", int'(flags_now()), int'(FLT));
    a = 8'h01;
    b = 8'h00;
    @(posedge clk);
    #1;
    start = 1'b0;
    accepts++;
    chk("b2b accepted", int'(busy), 1);
    cnt = 0;
    while (!done && cnt < int'(N) + 3) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    chk("b2b latency", cnt, 4);
    chk("b2b flags", int'(flags_now()), int'(FGT));

    // Randomised pairs against the reference model
    for (int i = 0; i < 1500; i++) begin
      ra = W'($urandom);
      sh = $urandom_range(0, 4);
      if (sh == 4) rb = ra;
      else rb = ra ^ (W'($urandom) & (8'hFF >> (2 * sh)));
      model(ra, rb, mf, ml);
      run_compare($sformatf("rand a=%02h b=%02h", ra, rb), ra, rb, mf, ml);
    end

    @(posedge clk);
    #1;
    chk("done_count", done_cnt, accepts);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
